// File: rtl/current_control_pi.sv
// current_control_pi: PI current loop with clamped integrator and saturating motor command
module current_control_pi #(
    parameter int WIDTH    = 12,
    parameter int KP       = 16,
    parameter int KI       = 1,
    parameter int SHIFT    = 4,
    parameter int DIV      = 32,
    parameter int DEADBAND = 3
) (
    input  logic             c20k,
    input  logic             nReset,
    input  logic             Enable,
    input  logic [WIDTH-1:0] Setpoint,
    input  logic [WIDTH-1:0] Feedback,
    output logic [WIDTH-1:0] MotorSignal,
    output logic             Saturated,
    output logic             UpdateStrobe
);
    localparam int EW = WIDTH + 1;
    localparam int IW = WIDTH + SHIFT + 10;
    localparam int CW = $clog2(DIV);
    localparam logic signed [IW-1:0] KP_S = IW'(KP);
    localparam logic signed [IW-1:0] KI_S = IW'(KI);
    localparam logic signed [IW-1:0] OMAX = IW'((64'(1) << WIDTH) - 64'(1));
    localparam logic signed [IW-1:0] IMAX = OMAX << SHIFT;
    localparam logic [WIDTH-1:0] DB = WIDTH'(DEADBAND);

    typedef enum logic [1:0] {IDLE, ERR, CALC, OUT} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q;
    logic                    tick;
    logic [WIDTH-1:0]        sp_q, fb_q;
    logic                    db_q;
    logic signed [EW-1:0]    err_q, err_d;
    logic signed [IW-1:0]    err_x, p_q, p_d, ic_q, ic_d, ic_raw, integ_q, sum;
    logic [WIDTH-1:0]        motor_q, motor_d;
    logic                    sat_q, sat_d, strobe_q;

    assign tick         = cnt_q == CW'(DIV - 1);
    assign MotorSignal  = motor_q;
    assign Saturated    = sat_q;
    assign UpdateStrobe = strobe_q;

    // free-running update-rate divider, unaffected by Enable
    always_ff @(posedge c20k or negedge nReset) begin
        if (!nReset) cnt_q <= '0;
        else         cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end

    // FSM state register
    always_ff @(posedge c20k or negedge nReset) begin
        if (!nReset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // sequencing: a tick launches ERR -> CALC -> OUT; Enable low parks the FSM in IDLE
    always_comb begin
        state_d = IDLE;
        state_d = !Enable         ? IDLE :
                  state_q == IDLE ? (tick ? ERR : IDLE) :
                  state_q == ERR  ? CALC :
                  state_q == CALC ? OUT  : IDLE;
    end

    // datapath: error, P term, clamped integrator candidate and saturated command
    always_comb begin
        err_d   = $signed({1'b0, sp_q}) - $signed({1'b0, fb_q});
        err_x   = {{(IW - EW){err_q[EW-1]}}, err_q};
        p_d     = err_x * KP_S;
        ic_raw  = integ_q + err_x * KI_S;
        ic_d    = ic_raw[IW-1] ? '0 : ic_raw > IMAX ? IMAX : ic_raw;
        sum     = (p_q + ic_q) >>> SHIFT;
        sat_d   = sum[IW-1] || sum > OMAX;
        motor_d = sum[IW-1] ? '0 : sum > OMAX ? '1 : sum[WIDTH-1:0];
    end

    // pipeline registers: inputs captured only on the tick, then one stage per state
    always_ff @(posedge c20k or negedge nReset) begin
        if (!nReset) begin
            sp_q  <= '0;
            fb_q  <= '0;
            db_q  <= 1'b0;
            err_q <= '0;
            p_q   <= '0;
            ic_q  <= '0;
        end else begin
            if (state_q == IDLE && tick && Enable) begin
                sp_q <= Setpoint;
                fb_q <= Feedback;
                db_q <= Setpoint <= DB;
            end
            if (state_q == ERR) err_q <= err_d;
            if (state_q == CALC) begin
                p_q  <= p_d;
                ic_q <= ic_d;
            end
        end
    end

    // commit integrator and outputs in OUT; Enable low clears them on the next edge
    always_ff @(posedge c20k or negedge nReset) begin
        if (!nReset) begin
            integ_q  <= '0;
            motor_q  <= '0;
            sat_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else if (!Enable) begin
            integ_q  <= '0;
            motor_q  <= '0;
            sat_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= state_q == OUT;
            if (state_q == OUT) begin
                integ_q <= db_q ? '0 : ic_q;
                motor_q <= db_q ? '0 : motor_d;
                sat_q   <= !db_q && sat_d;
            end
        end
    end
endmodule

// File: tb/tb_current_control_pi.sv
// tb_current_control_pi: randomized scoreboard bench for the PI current loop
module tb_current_control_pi;
    localparam int W    = 12;
    localparam int KP   = 16;
    localparam int KI   = 1;
    localparam int SH   = 4;
    localparam int DIV  = 32;
    localparam int DB   = 3;
    localparam int OMAX = (1 << W) - 1;
    localparam int IMAX = OMAX * (1 << SH);

    typedef struct {
        int m;
        int s;
    } exp_t;

    logic         clk, nReset, Enable;
    logic [W-1:0] Setpoint, Feedback, MotorSignal;
    logic         Saturated, UpdateStrobe;

    exp_t sb[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;
    int   integ_m    = 0;
    int   hold_m     = 0;
    int   hold_s     = 0;
    int   ecnt       = 0;

    current_control_pi #(
        .WIDTH(W), .KP(KP), .KI(KI), .SHIFT(SH), .DIV(DIV), .DEADBAND(DB)
    ) dut (
        .c20k(clk),
        .nReset(nReset),
        .Enable(Enable),
        .Setpoint(Setpoint),
        .Feedback(Feedback),
        .MotorSignal(MotorSignal),
        .Saturated(Saturated),
        .UpdateStrobe(UpdateStrobe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // edges since reset release; an update is launched on every DIV-th edge
    always @(posedge clk or negedge nReset) begin
        if (!nReset) ecnt <= 0;
        else         ecnt <= ecnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if (a < 0 && a % d != 0) q = q - 1;
        return q;
    endfunction

    // reference model: one loop update from the sampled inputs, result queued for the monitor
    task automatic issue(input int sp, input int fb);
        exp_t e;
        int   err, p, ic, f;
        if (sp <= DB) begin
            integ_m = 0;
            e.m = 0;
            e.s = 0;
        end else begin
            err = sp - fb;
            p   = err * KP;
            ic  = integ_m + err * KI;
            if (ic < 0) ic = 0;
            if (ic > IMAX) ic = IMAX;
            integ_m = ic;
            f   = floor_div(p + ic, 1 << SH);
            e.s = (f < 0 || f > OMAX) ? 1 : 0;
            e.m = f < 0 ? 0 : (f > OMAX ? OMAX : f);
        end
        sb.push_back(e);
    endtask

    // scoreboard monitor: compare on each strobe, otherwise outputs must hold
    always @(negedge clk) begin
        if (nReset) begin
            if (UpdateStrobe) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_strobe: got strobe with motor %0d, required no strobe", MotorSignal);
                end else begin
                    mon_e = sb.pop_front();
                    chk("motor", int'(MotorSignal), mon_e.m);
                    chk("saturated", int'(Saturated), mon_e.s);
                    hold_m = mon_e.m;
                    hold_s = mon_e.s;
                end
            end else if (Enable) begin
                chk("hold_motor", int'(MotorSignal), hold_m);
                chk("hold_sat", int'(Saturated), hold_s);
            end
        end
    end

    // park on the negedge just before the next tick edge, scrambling inputs meanwhile
    task automatic wait_pre_tick();
        @(negedge clk);
        while (ecnt % DIV != DIV - 1) begin
            Setpoint = W'($urandom);
            Feedback = W'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic do_update(input int sp, input int fb);
        wait_pre_tick();
        Setpoint = W'(sp);
        Feedback = W'(fb);
        issue(sp, fb);
        @(negedge clk);
        Setpoint = W'($urandom);
        Feedback = W'($urandom);
        chk("strobe_t0", int'(UpdateStrobe), 0);
        @(negedge clk);
        chk("strobe_t1", int'(UpdateStrobe), 0);
        @(negedge clk);
        chk("strobe_t2", int'(UpdateStrobe), 0);
        @(negedge clk);
        chk("strobe_t3", int'(UpdateStrobe), 1);
    endtask

    initial begin
        int sp, fb;
        nReset   = 1'b1;
        Enable   = 1'b1;
        Setpoint = W'(4);
        Feedback = '0;
        #3 nReset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_motor", int'(MotorSignal), 0);
            chk("reset_sat", int'(Saturated), 0);
            chk("reset_strobe", int'(UpdateStrobe), 0);
        end
        @(negedge clk);
        nReset = 1'b1;
        do_update(4, 0);
        chk("first_update", int'(MotorSignal), 4);

        wait_pre_tick();
        Setpoint = W'(4);
        Feedback = '0;
        issue(4, 0);
        repeat (3) @(negedge clk);
        #2 nReset = 1'b0;
        void'(sb.pop_back());
        integ_m = 0;
        hold_m  = 0;
        hold_s  = 0;
        #1;
        chk("abort_motor", int'(MotorSignal), 0);
        chk("abort_sat", int'(Saturated), 0);
        @(negedge clk);
        chk("abort_no_strobe", int'(UpdateStrobe), 0);
        @(negedge clk);
        nReset = 1'b1;

        for (int i = 1; i <= 20; i++) begin
            do_update(4, 0);
            if (i == 1) chk("step_u1", int'(MotorSignal), 4);
            if (i == 4) chk("step_u4", int'(MotorSignal), 5);
            if (i == 16) chk("step_u16", int'(MotorSignal), 8);
        end

        repeat (10) do_update(3, 0);
        chk("deadband_motor", int'(MotorSignal), 0);
        do_update(4, 0);
        chk("deadband_release", int'(MotorSignal), 4);

        for (int i = 1; i <= 18; i++) begin
            do_update(4095, 0);
            if (i == 1) begin
                chk("high_u1_motor", int'(MotorSignal), 4095);
                chk("high_u1_sat", int'(Saturated), 1);
            end
        end
        do_update(2000, 2000);
        chk("windup_motor", int'(MotorSignal), 4095);
        chk("windup_sat", int'(Saturated), 0);

        wait_pre_tick();
        Setpoint = W'(4095);
        Feedback = '0;
        issue(4095, 0);
        @(posedge clk);
        @(posedge clk);
        #1 Enable = 1'b0;
        void'(sb.pop_back());
        integ_m = 0;
        hold_m  = 0;
        hold_s  = 0;
        #1 chk("endrop_before", int'(MotorSignal), 4095);
        @(posedge clk);
        #1;
        chk("endrop_motor", int'(MotorSignal), 0);
        chk("endrop_sat", int'(Saturated), 0);
        @(posedge clk);
        #1 chk("endrop_no_strobe", int'(UpdateStrobe), 0);
        @(negedge clk);
        #1 Enable = 1'b1;
        do_update(4, 0);
        chk("endrop_rebuild", int'(MotorSignal), 4);

        do_update(100, 4000);
        chk("neg_motor", int'(MotorSignal), 0);
        chk("neg_sat", int'(Saturated), 1);
        do_update(100, 96);
        chk("neg_recover", int'(MotorSignal), 4);

        for (int i = 0; i < 40; i++) begin
            sp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 4095));
            fb = int'($urandom_range(0, 4095));
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                #1 Enable = 1'b0;
                integ_m = 0;
                hold_m  = 0;
                hold_s  = 0;
                repeat ($urandom_range(1, 2 * DIV)) @(negedge clk);
                while (ecnt % DIV == DIV - 1) @(negedge clk);
                #1 Enable = 1'b1;
            end
            do_update(sp, fb);
        end

        repeat (4) @(negedge clk);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL pending_updates: got %0d outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
